// File: rtl/recover_2n_fft.sv
// Rebuilds a 2N-point real FFT (N = 8192) from an N-point complex FFT of the packed sequence.
// Optional macro RECOVER_2N_FFT_ROUND_EN switches both shifts from floor to round half-up.
module recover_2n_fft #(
    parameter int DATA_WIDTH = 27,
    parameter int TWID_WIDTH = 16,
    parameter int LSB_CUTOFF = 12,
    parameter int SHIFT      = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    output logic                        ready,
    input  logic [3:0][DATA_WIDTH-1:0]  x1_col1_r,
    input  logic [3:0][DATA_WIDTH-1:0]  x1_col1_i,
    input  logic [3:0][DATA_WIDTH-1:0]  x2_col1_r,
    input  logic [3:0][DATA_WIDTH-1:0]  x2_col1_i,
    input  logic [10:0]                 index_col_1,
    input  logic [3:0][DATA_WIDTH-1:0]  x1_col2_r,
    input  logic [3:0][DATA_WIDTH-1:0]  x1_col2_i,
    input  logic [3:0][DATA_WIDTH-1:0]  x2_col2_r,
    input  logic [3:0][DATA_WIDTH-1:0]  x2_col2_i,
    input  logic [10:0]                 index_col_2,
    output logic [3:0][31:0]            dataout_col1_r,
    output logic [3:0][31:0]            dataout_col1_i,
    output logic [3:0][31:0]            dataout_col2_r,
    output logic [3:0][31:0]            dataout_col2_i
);

    localparam int  N     = 8192;
    localparam int  KW    = 13;
    localparam int  LANES = 8;
    localparam int  EW    = DATA_WIDTH + 1;
    localparam int  W     = DATA_WIDTH + TWID_WIDTH + 2;
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP   = real'((1 << (TWID_WIDTH - 1)) - 1);

`ifdef RECOVER_2N_FFT_ROUND_EN
    localparam logic signed [W-1:0] RND_P = W'(1) << (SHIFT - 1);
    localparam logic signed [W-1:0] RND_H = W'(1);
`else
    localparam logic signed [W-1:0] RND_P = '0;
    localparam logic signed [W-1:0] RND_H = '0;
`endif

    if (LSB_CUTOFF > SHIFT) begin : g_bad_cutoff
        $error("LSB_CUTOFF must not exceed SHIFT");
    end

    // Twiddle ROM contents are elaboration-time constants: round(AMP * cos/sin(pi*k/N)).
    logic signed [TWID_WIDTH-1:0] cos_rom [N];
    logic signed [TWID_WIDTH-1:0] sin_rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam real ANG = PI * real'(g) / real'(N);
        assign cos_rom[g] = TWID_WIDTH'($rtoi($floor(AMP * $cos(ANG) + 0.5)));
        assign sin_rom[g] = TWID_WIDTH'($rtoi($floor(AMP * $sin(ANG) + 0.5)));
    end

    // Lanes 0..3 are column 1, lanes 4..7 are column 2.
    logic signed [DATA_WIDTH-1:0] in_ar [LANES];
    logic signed [DATA_WIDTH-1:0] in_ai [LANES];
    logic signed [DATA_WIDTH-1:0] in_br [LANES];
    logic signed [DATA_WIDTH-1:0] in_bi [LANES];
    logic        [KW-1:0]         in_k  [LANES];

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            in_ar[l]     = x1_col1_r[l];
            in_ai[l]     = x1_col1_i[l];
            in_br[l]     = x2_col1_r[l];
            in_bi[l]     = x2_col1_i[l];
            in_k[l]      = {index_col_1, 2'(l)};
            in_ar[l + 4] = x1_col2_r[l];
            in_ai[l + 4] = x1_col2_i[l];
            in_br[l + 4] = x2_col2_r[l];
            in_bi[l + 4] = x2_col2_i[l];
            in_k[l + 4]  = {index_col_2, 2'(l)};
        end
    end

    logic [2:0] vld_q;

    logic signed [DATA_WIDTH-1:0] s1_ar [LANES];
    logic signed [DATA_WIDTH-1:0] s1_ai [LANES];
    logic signed [DATA_WIDTH-1:0] s1_br [LANES];
    logic signed [DATA_WIDTH-1:0] s1_bi [LANES];
    logic signed [TWID_WIDTH-1:0] s1_c  [LANES];
    logic signed [TWID_WIDTH-1:0] s1_s  [LANES];

    logic signed [EW-1:0]         s2_er [LANES];
    logic signed [EW-1:0]         s2_ei [LANES];
    logic signed [EW-1:0]         s2_or [LANES];
    logic signed [EW-1:0]         s2_oi [LANES];
    logic signed [TWID_WIDTH-1:0] s2_c  [LANES];
    logic signed [TWID_WIDTH-1:0] s2_s  [LANES];

    logic signed [EW-1:0]         s3_er [LANES];
    logic signed [EW-1:0]         s3_ei [LANES];
    logic signed [W-1:0]          s3_pr [LANES];
    logic signed [W-1:0]          s3_pi [LANES];

    logic signed [W-1:0]          p_r   [LANES];
    logic signed [W-1:0]          p_i   [LANES];
    logic signed [W-1:0]          sum_r [LANES];
    logic signed [W-1:0]          sum_i [LANES];

    logic        [31:0]           out_r [LANES];
    logic        [31:0]           out_i [LANES];

    // Stages 1-3 advance every cycle regardless of valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_ar[l] <= '0;
                s1_ai[l] <= '0;
                s1_br[l] <= '0;
                s1_bi[l] <= '0;
                s1_c[l]  <= '0;
                s1_s[l]  <= '0;
                s2_er[l] <= '0;
                s2_ei[l] <= '0;
                s2_or[l] <= '0;
                s2_oi[l] <= '0;
                s2_c[l]  <= '0;
                s2_s[l]  <= '0;
                s3_er[l] <= '0;
                s3_ei[l] <= '0;
                s3_pr[l] <= '0;
                s3_pi[l] <= '0;
            end
        end else begin
            vld_q <= {vld_q[1:0], valid};
            for (int l = 0; l < LANES; l++) begin
                s1_ar[l] <= in_ar[l];
                s1_ai[l] <= in_ai[l];
                s1_br[l] <= in_br[l];
                s1_bi[l] <= in_bi[l];
                s1_c[l]  <= cos_rom[in_k[l]];
                s1_s[l]  <= sin_rom[in_k[l]];

                s2_er[l] <= EW'(s1_ar[l]) + EW'(s1_br[l]);
                s2_ei[l] <= EW'(s1_ai[l]) - EW'(s1_bi[l]);
                s2_or[l] <= EW'(s1_ai[l]) + EW'(s1_bi[l]);
                s2_oi[l] <= EW'(s1_br[l]) - EW'(s1_ar[l]);
                s2_c[l]  <= s1_c[l];
                s2_s[l]  <= s1_s[l];

                s3_er[l] <= s2_er[l];
                s3_ei[l] <= s2_ei[l];
                s3_pr[l] <= W'(s2_c[l]) * W'(s2_or[l]) + W'(s2_s[l]) * W'(s2_oi[l]);
                s3_pi[l] <= W'(s2_c[l]) * W'(s2_oi[l]) - W'(s2_s[l]) * W'(s2_or[l]);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            p_r[l]   = (s3_pr[l] + RND_P) >>> SHIFT;
            p_i[l]   = (s3_pi[l] + RND_P) >>> SHIFT;
            sum_r[l] = W'(s3_er[l]) + p_r[l] + RND_H;
            sum_i[l] = W'(s3_ei[l]) + p_i[l] + RND_H;
        end
    end

    // Output registers only capture beats that were valid; otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                out_r[l] <= '0;
                out_i[l] <= '0;
            end
        end else begin
            ready <= vld_q[2];
            if (vld_q[2]) begin
                for (int l = 0; l < LANES; l++) begin
                    out_r[l] <= 32'(sum_r[l] >>> 1);
                    out_i[l] <= 32'(sum_i[l] >>> 1);
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            dataout_col1_r[l] = out_r[l];
            dataout_col1_i[l] = out_i[l];
            dataout_col2_r[l] = out_r[l + 4];
            dataout_col2_i[l] = out_i[l + 4];
        end
    end

endmodule

// File: tb/tb_recover_2n_fft.sv
// Scoreboard bench for recover_2n_fft: randomized and directed beats checked against a
// formula-level model; honours RECOVER_2N_FFT_ROUND_EN the same way as the design.
module tb_recover_2n_fft;

    localparam int DW = 27;

`ifdef RECOVER_2N_FFT_ROUND_EN
    localparam longint RP = 64'd16384;
    localparam longint RH = 64'd1;
`else
    localparam longint RP = 64'd0;
    localparam longint RH = 64'd0;
`endif

    typedef struct packed {
        int             due;
        bit             c2;
        logic [7:0][31:0] xr;
        logic [7:0][31:0] xi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic ready;
    logic [3:0][DW-1:0] x1_col1_r, x1_col1_i, x2_col1_r, x2_col1_i;
    logic [3:0][DW-1:0] x1_col2_r, x1_col2_i, x2_col2_r, x2_col2_i;
    logic [10:0] index_col_1, index_col_2;
    logic [3:0][31:0] dataout_col1_r, dataout_col1_i, dataout_col2_r, dataout_col2_i;

    recover_2n_fft dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .ready         (ready),
        .x1_col1_r     (x1_col1_r),
        .x1_col1_i     (x1_col1_i),
        .x2_col1_r     (x2_col1_r),
        .x2_col1_i     (x2_col1_i),
        .index_col_1   (index_col_1),
        .x1_col2_r     (x1_col2_r),
        .x1_col2_i     (x1_col2_i),
        .x2_col2_r     (x2_col2_r),
        .x2_col2_i     (x2_col2_i),
        .index_col_2   (index_col_2),
        .dataout_col1_r(dataout_col1_r),
        .dataout_col1_i(dataout_col1_i),
        .dataout_col2_r(dataout_col2_r),
        .dataout_col2_i(dataout_col2_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int run_len = 0;
    int max_run = 0;
    logic [7:0][31:0] last_r = '0;
    logic [7:0][31:0] last_i = '0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint tw(input int k, input bit sine);
        real a;
        a = 3.14159265358979323846 * real'(k) / 8192.0;
        return longint'($rtoi($floor(32767.0 * (sine ? $sin(a) : $cos(a)) + 0.5)));
    endfunction

    // X[k] straight from the butterfly equations, in 64-bit integers.
    function automatic void model(input longint ar, input longint ai, input longint br,
                                  input longint bi, input int k,
                                  output longint xr, output longint xi);
        longint er, ei, orr, oi, c, s, pr, pim;
        er  = ar + br;
        ei  = ai - bi;
        orr = ai + bi;
        oi  = br - ar;
        c   = tw(k, 1'b0);
        s   = tw(k, 1'b1);
        pr  = (c * orr + s * oi + RP) >>> 15;
        pim = (c * oi - s * orr + RP) >>> 15;
        xr  = (er + pr + RH) >>> 1;
        xi  = (ei + pim + RH) >>> 1;
    endfunction

    function automatic int bitrev11(input int v);
        int r = 0;
        for (int b = 0; b < 11; b++) if (v[b]) r[10-b] = 1'b1;
        return r;
    endfunction

    // Called right after an active edge: the beat is sampled next edge, output 4 edges later.
    task automatic push_beat(input bit c2);
        exp_t e;
        longint xr, xi;
        e.due = cyc + 4;
        e.c2  = c2;
        for (int l = 0; l < 4; l++) begin
            model(longint'($signed(x1_col1_r[l])), longint'($signed(x1_col1_i[l])),
                  longint'($signed(x2_col1_r[l])), longint'($signed(x2_col1_i[l])),
                  int'(index_col_1) * 4 + l, xr, xi);
            e.xr[l] = 32'(xr);
            e.xi[l] = 32'(xi);
            model(longint'($signed(x1_col2_r[l])), longint'($signed(x1_col2_i[l])),
                  longint'($signed(x2_col2_r[l])), longint'($signed(x2_col2_i[l])),
                  int'(index_col_2) * 4 + l, xr, xi);
            e.xr[l+4] = 32'(xr);
            e.xi[l+4] = 32'(xi);
        end
        q.push_back(e);
        valid = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < 4; l++) begin
            x1_col1_r[l] = DW'($urandom);
            x1_col1_i[l] = DW'($urandom);
            x2_col1_r[l] = DW'($urandom);
            x2_col1_i[l] = DW'($urandom);
            x1_col2_r[l] = DW'($urandom);
            x1_col2_i[l] = DW'($urandom);
            x2_col2_r[l] = DW'($urandom);
            x2_col2_i[l] = DW'($urandom);
        end
        index_col_1 = 11'($urandom);
        index_col_2 = 11'($urandom);
    endtask

    task automatic set_lane0(input int ar, input int ai, input int br, input int bi);
        x1_col1_r[0] = DW'(ar);
        x1_col1_i[0] = DW'(ai);
        x2_col1_r[0] = DW'(br);
        x2_col1_i[0] = DW'(bi);
    endtask

    // Monitor: compares ready every cycle and pops the scoreboard when a beat is due.
    always @(negedge clk) begin
        exp_t e;
        bit exp_rdy;
        if (rst) begin
            last_r  = '0;
            last_i  = '0;
            run_len = 0;
        end else begin
            while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
            exp_rdy = (q.size() > 0) && (q[0].due == cyc);
            chk("ready", longint'(ready), longint'(exp_rdy));
            if (ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (exp_rdy) begin
                e = q.pop_front();
                for (int l = 0; l < 4; l++) begin
                    chk($sformatf("c1_r%0d", l), longint'($signed(dataout_col1_r[l])),
                        longint'($signed(e.xr[l])));
                    chk($sformatf("c1_i%0d", l), longint'($signed(dataout_col1_i[l])),
                        longint'($signed(e.xi[l])));
                    if (e.c2) begin
                        chk($sformatf("c2_r%0d", l), longint'($signed(dataout_col2_r[l])),
                            longint'($signed(e.xr[l+4])));
                        chk($sformatf("c2_i%0d", l), longint'($signed(dataout_col2_i[l])),
                            longint'($signed(e.xi[l+4])));
                    end
                end
                last_r = e.xr;
                last_i = e.xi;
            end else if (!ready) begin
                for (int l = 0; l < 4; l++) begin
                    chk($sformatf("hold_r%0d", l), longint'($signed(dataout_col1_r[l])),
                        longint'($signed(last_r[l])));
                    chk($sformatf("hold_i%0d", l), longint'($signed(dataout_col1_i[l])),
                        longint'($signed(last_i[l])));
                end
            end
        end
    end

    initial begin
        int idxs[$];
        rand_lanes();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) next_cycle();

        // DC bin
        rand_lanes();
        index_col_1 = 11'd0;
        set_lane0(1000, 0, 1000, 0);
        push_beat(1'b1);
        q[q.size()-1].xr[0] = 32'sd1000;
        q[q.size()-1].xi[0] = 32'sd0;
        next_cycle();
        // Imaginary-only
        rand_lanes();
        index_col_1 = 11'd0;
        set_lane0(0, 1000, 0, -1000);
        push_beat(1'b1);
        q[q.size()-1].xr[0] = 32'sd0;
        q[q.size()-1].xi[0] = 32'sd1000;
        next_cycle();
        // Quarter twiddle, k = 4096
        rand_lanes();
        index_col_1 = 11'd1024;
        set_lane0(1000, 0, -1000, 0);
        push_beat(1'b1);
        q[q.size()-1].xr[0] = -32'sd1000;
        q[q.size()-1].xi[0] = 32'sd0;
        next_cycle();
        // Negative extremes on every lane
        rand_lanes();
        for (int l = 0; l < 4; l++) begin
            x1_col1_r[l] = DW'(-(1 << 26));
            x1_col1_i[l] = DW'(-(1 << 26));
            x2_col1_r[l] = DW'(-(1 << 26));
            x2_col1_i[l] = DW'(-(1 << 26));
            x1_col2_r[l] = DW'(-(1 << 26));
            x1_col2_i[l] = DW'(-(1 << 26));
            x2_col2_r[l] = DW'(-(1 << 26));
            x2_col2_i[l] = DW'(-(1 << 26));
        end
        push_beat(1'b1);
        next_cycle();
        valid = 1'b0;
        repeat (3) next_cycle();

        // Random stream with gaps, reset asserted mid-stream
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #1;
                rst = 1'b1;
                #1;
                chk("rst_ready", longint'(ready), 0);
                for (int l = 0; l < 4; l++) begin
                    chk("rst_out_c1r", longint'(dataout_col1_r[l]), 0);
                    chk("rst_out_c1i", longint'(dataout_col1_i[l]), 0);
                    chk("rst_out_c2r", longint'(dataout_col2_r[l]), 0);
                    chk("rst_out_c2i", longint'(dataout_col2_i[l]), 0);
                end
                q.delete();
                valid = 1'b0;
                repeat (2) next_cycle();
                rst = 1'b0;
                repeat (2) next_cycle();
                rand_lanes();
                push_beat(1'b1);
                next_cycle();
                valid = 1'b0;
                repeat (7) next_cycle();
            end
            if ($urandom_range(0, 9) < 7) begin
                rand_lanes();
                push_beat(1'($urandom));
            end else begin
                valid = 1'b0;
            end
            next_cycle();
        end
        valid = 1'b0;
        repeat (8) next_cycle();

        // Full frame: 1025 contiguous beats with bit-reversed column indices
        for (int j = 1; j < 2048; j++) if (j != 1024) idxs.push_back(bitrev11(j));
        max_run = 0;
        for (int b = 0; b < 1025; b++) begin
            rand_lanes();
            if (b < 2) begin
                index_col_1 = 11'(b);
                push_beat(1'b0);
            end else begin
                index_col_1 = 11'(idxs[2*(b-2)]);
                index_col_2 = 11'(idxs[2*(b-2)+1]);
                push_beat(1'b1);
            end
            next_cycle();
        end
        valid = 1'b0;
        repeat (8) next_cycle();
        chk("frame_ready_run", longint'(max_run), 1025);
        chk("queue_drained", longint'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/recover_2n_fft.md
Name: recover_2n_fft

Overview:
- Post-processing stage that rebuilds a 2N-point real-input FFT (N = 8192, so 16384 points) from an N-point complex FFT of the packed sequence z[n] = x[2n] + j·x[2n+1].
- Per cycle it takes up to two 4-lane "columns" of complex bins: x1 = Z[k] and x2 = the partner bin Z[(N−k) mod N].
- It applies the split/twiddle butterfly with an internal twiddle ROM and streams X[k] out at a fixed latency.
- It sits between the N-point FFT core's output reorder and the spectrum sink.

Parameters:
- DATA_WIDTH, 27: input component width, two's complement.
- TWID_WIDTH, 16: twiddle component width, signed Q1.(TWID_WIDTH−1).
- LSB_CUTOFF, 12: reserved for interface compatibility; has no functional effect. Legal values are LSB_CUTOFF ≤ SHIFT.
- SHIFT, 15: right shift applied to twiddle products; equals TWID_WIDTH−1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-high reset.
- valid, input, 1: input beat valid.
- ready, output, 1: output beat valid.
- x1_col1_r / x1_col1_i, input, [3:0][DATA_WIDTH-1:0]: Z[k], column 1, lanes 0..3.
- x2_col1_r / x2_col1_i, input, [3:0][DATA_WIDTH-1:0]: Z[(N−k) mod N], column 1.
- index_col_1, input, 11: column-1 base index. Lane bin k = {index_col_1, lane[1:0]}.
- x1_col2_r/_i, x2_col2_r/_i, index_col_2: same as column 1, for column 2.
- dataout_col1_r / dataout_col1_i, output, [3:0][31:0]: X[k] for column 1.
- dataout_col2_r / dataout_col2_i, output, [3:0][31:0]: X[k] for column 2.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Twiddle ROM: 8192 entries indexed by the 13-bit k.
  - c[k] = round(32767·cos(πk/8192)), s[k] = round(32767·sin(πk/8192)).
  - Both columns and all 8 lanes read the ROM in parallel.
- Per-lane arithmetic, with A = x1, B = x2, all signed:
  - Er = Ar + Br; Ei = Ai − Bi.
  - Or = Ai + Bi; Oi = Br − Ar.
  - Pr = (c·Or + s·Oi) >>> SHIFT; Pi = (c·Oi − s·Or) >>> SHIFT.
  - Intermediate width is DATA_WIDTH+TWID_WIDTH+2; there is no overflow anywhere.
  - Xr = (Er + Pr) >>> 1; Xi = (Ei + Pi) >>> 1.
  - Shifts are arithmetic (floor); results are sign-extended to 32 bits.
- Pipeline: fully pipelined, one beat per cycle, latency 4 cycles.
  - Stage 1: register inputs and ROM read.
  - Stage 2: compute E and O sums.
  - Stage 3: multiplies.
  - Stage 4: final add and shift into the output registers.
- ready equals valid delayed exactly 4 cycles. Gaps in valid produce identical gaps in ready.
- The pipeline advances every cycle. Outputs update only when the corresponding beat had valid=1; otherwise they hold their previous value.
- Column 2 is processed unconditionally. On beats where the upstream drives only column 1 (the first two beats of a frame), column-2 outputs are don't-care.
- Frame: 1025 beats.
  - Beats 0–1 carry column 1 only (bins 0..7).
  - Beats 2..1024 carry both columns (8 bins each).
  - The block has no frame counter; it is stateless apart from the pipeline.
- k=0 and k=N/2 need no special case. The supplier provides the wrapped partner: x2 = Z[0] for k = 0. X[N] is not produced.
- Reset: all pipeline registers, outputs and ready go to 0 immediately. Beats in flight are discarded. After deassertion, the first ready comes 4 cycles after the first accepted valid.

Optional Feature:
- Macro: RECOVER_2N_FFT_ROUND_EN.
- Defined: both >>> SHIFT and >>> 1 round half-up, i.e. add 2^(SHIFT−1) before the product shift and add 1 before the final halving. Latency is unchanged.
- Undefined: truncation (floor), as specified above.

Test Plan:
- Reset/latency: assert rst mid-stream → ready=0 and outputs=0 immediately. After release, a valid pulse on cycle t gives ready=1 exactly at cycle t+4, for exactly one cycle.
- DC bin: k=0, x1=(1000,0), x2=(1000,0) → X=(1000,0).
- Imaginary-only: k=0, x1=(0,1000), x2=(0,−1000) → X=(0,1000).
- Quarter twiddle: index_col_1=1024, lane 0 (k=4096), x1=(1000,0), x2=(−1000,0) → X=(−1000,0) truncating; X=(−1000,0) with ROUND_EN.
- Full frame: 1025 beats of random 27-bit data with bit-reversed indices → all 8192 outputs match a bit-accurate model of the formulas. ready is high for exactly 1025 contiguous cycles.
- Negative extremes: x1=x2=(−2^26, −2^26) on all lanes → no wrap, and each output equals the model, correctly sign-extended to 32 bits.
